evr_link_supervisor: RTL
========================

# evr_link_supervisor

Sequences bring-up and recovery of the EVR GTY receive link on `sysClk`. It drives the wizard's full reset and RX datapath reset, qualifies the link from RX activity, and declares `link_up`. On link loss or buffer-bypass error it retries with escalating resets. The block sits beside the EVR transceiver wrapper. Its outputs gate downstream consumers such as `TimeStamp` / `dma_evt_trig` users and feed a status register.

## Interface
Parameters:
- `RST_PULSE`, 100: cycles `gt_reset_all` / `rx_dp_reset` are held high
- `DONE_TIMEOUT`, 2_000_000: max cycles in WAIT_DONE before retry
- `ACT_TIMEOUT`, 1024: max cycles between RX activity edges before the link counts as dead
- `QUAL_CYCLES`, 65536: continuous healthy cycles required before `link_up`
- `MAX_RX_RETRY`, 3: consecutive RX-only resets before escalating to a full reset

Ports (clock and reset first):
- `sysClk` in 1: the block's single clock, free-running
- `reset` in 1: asynchronous, active-high; all state and outputs cleared
- `force_reset` in 1: `sysClk` pulse requesting an immediate full reset
- `gt_powergood` in 1: async level, synchronized internally
- `tx_done` in 1: async level (wizard reset TX done)
- `rx_done` in 1: async level (wizard reset RX done)
- `bb_rx_done` in 1: async level (RX buffer-bypass done)
- `bb_rx_error` in 1: async level (RX buffer-bypass error)
- `rx_act_toggle` in 1: toggles in the RX clock domain on every comma/valid event; async
- `gt_reset_all` out 1: to wizard `gtwiz_reset_all_in` (OR'd with top reset upstream)
- `rx_dp_reset` out 1: to wizard `gtwiz_reset_rx_datapath_in`
- `link_up` out 1: link qualified and healthy
- `state` out 3: encoded FSM state
- `retry_cnt` out 2: current consecutive RX retries
- `loss_cnt` out 16: saturating count of LINK_UP exits

## Operation
- Every async input passes through a 2-FF synchronizer on `sysClk`.
- `act_edge` = synced toggle XOR its 1-cycle delayed copy.
- Activity counter `act_cnt`: cleared on `act_edge`, otherwise increments, saturating at `ACT_TIMEOUT`. `dead` = (`act_cnt` == `ACT_TIMEOUT`).
- FSM states and encodings:
  - HOLD=0: outputs low. Exit to FULL_RST when `pg_s`=1.
  - FULL_RST=1: `gt_reset_all`=1 for `RST_PULSE` cycles. Clears `retry_cnt`, then goes to WAIT_DONE.
  - WAIT_DONE=2: waits for `tx_done_s & rx_done_s & bb_rx_done_s`, then goes to QUALIFY.
    - Timeout counter reaching `DONE_TIMEOUT` goes to RX_RST, or to FULL_RST if `retry_cnt`==`MAX_RX_RETRY`.
  - QUALIFY=3: `qual_cnt` counts cycles with `!dead & !bb_err_s & bb_done_s`.
    - Any failing cycle clears `qual_cnt`.
    - `qual_cnt`==`QUAL_CYCLES`-1 on a healthy cycle goes to LINK_UP and clears `retry_cnt`.
    - A failure persisting `DONE_TIMEOUT` cycles counts as a WAIT_DONE timeout (same escalation rule).
  - LINK_UP=4: `link_up`=1.
    - `dead` or `bb_err_s` or `!rx_done_s`: increment `loss_cnt` (saturating at 0xFFFF), go to RX_RST.
  - RX_RST=5: `rx_dp_reset`=1 for `RST_PULSE` cycles, increment `retry_cnt`, go to WAIT_DONE.
- Escalation: entering RX_RST with `retry_cnt`==`MAX_RX_RETRY` goes to FULL_RST instead.
- Global overrides, checked in priority order every cycle:
  - `pg_s`=0 goes to HOLD from any state.
  - `force_reset` goes to FULL_RST, including from mid-pulse, where the pulse counter restarts.
  - A simultaneous `force_reset` and `pg_s`=0 resolves to HOLD.
- All counters restart on every state entry.

## Timing
- Reset values: `state`=HOLD, all outputs 0, all counters 0.
- Input-to-FSM latency: 2 cycles (synchronizer), plus 1 registered state cycle.
- `gt_reset_all` / `rx_dp_reset` are registered and asserted the cycle after state entry, exactly `RST_PULSE` cycles wide.
- `link_up` rises the cycle LINK_UP is entered and falls the cycle after the failing condition is sampled.
- `loss_cnt` updates on the same edge.
- `act_cnt` saturates and never wraps. `loss_cnt` saturates and never wraps.
- `reset` mid-pulse drops the pulse outputs asynchronously.

## Test plan
Use `RST_PULSE`=4, `DONE_TIMEOUT`=50, `ACT_TIMEOUT`=8, `QUAL_CYCLES`=20.

1. Bring-up:
   - Stimulus: powergood=1 after reset; all done at cycle 30; toggle every 4 cycles.
   - Required: `gt_reset_all` high exactly 4 cycles; `link_up`=1 at 20 healthy cycles after done + 3 cycles.
2. Activity loss:
   - Stimulus: stop toggling in LINK_UP.
   - Required: after 8 + 2 cycles, `link_up`=0, `loss_cnt`=1, `rx_dp_reset` pulse of 4 cycles, `retry_cnt`=1.
3. Escalation:
   - Stimulus: keep done low.
   - Required: three RX_RST passes, each 50 cycles apart, then FULL_RST with `retry_cnt` cleared.
4. Power loss:
   - Stimulus: drop powergood during FULL_RST.
   - Required: HOLD, `gt_reset_all`=0 immediately after sync; on restore, a fresh 4-cycle pulse.
5. Simultaneous events:
   - `force_reset` with powergood low resolves to HOLD.
   - `force_reset` alone in QUALIFY resolves to FULL_RST.
   - Async `reset` mid-`rx_dp_reset` clears all outputs before the next edge.

Source files
------------

// File: rtl/evr_link_supervisor.sv
// Bring-up and recovery sequencer for the EVR GTY receive link: drives the wizard
// resets, qualifies the link from RX activity and retries with escalating resets.
module evr_link_supervisor #(
    parameter int RST_PULSE    = 100,
    parameter int DONE_TIMEOUT = 2_000_000,
    parameter int ACT_TIMEOUT  = 1024,
    parameter int QUAL_CYCLES  = 65536,
    parameter int MAX_RX_RETRY = 3
) (
    input  logic        sysClk,
    input  logic        reset,
    input  logic        force_reset,
    input  logic        gt_powergood,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic        bb_rx_done,
    input  logic        bb_rx_error,
    input  logic        rx_act_toggle,
    output logic        gt_reset_all,
    output logic        rx_dp_reset,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [1:0]  retry_cnt,
    output logic [15:0] loss_cnt
);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        FULL_RST  = 3'd1,
        WAIT_DONE = 3'd2,
        QUALIFY   = 3'd3,
        LINK_UP   = 3'd4,
        RX_RST    = 3'd5
    } sup_state_t;

    localparam int TMR_MAX = (DONE_TIMEOUT > RST_PULSE) ? DONE_TIMEOUT : RST_PULSE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int ACT_W   = $clog2(ACT_TIMEOUT + 1);
    localparam int QUAL_W  = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;

    localparam logic [TMR_W-1:0]  TMR_SAT    = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0]  PULSE_LAST = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0]  DONE_LAST  = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [ACT_W-1:0]  ACT_SAT    = ACT_W'(ACT_TIMEOUT);
    localparam logic [QUAL_W-1:0] QUAL_LAST  = QUAL_W'(QUAL_CYCLES - 1);
    localparam logic [1:0]        RETRY_MAX  = 2'(MAX_RX_RETRY);

    sup_state_t        state_q, next_state, escal_state;
    logic [5:0]        sync1, sync2;
    logic              pg_s, tx_done_s, rx_done_s, bb_done_s, bb_err_s, act_s;
    logic              act_d, act_edge, dead, healthy, all_done, entering;
    logic [ACT_W-1:0]  act_cnt;
    logic [TMR_W-1:0]  tmr, tmr_next;
    logic [QUAL_W-1:0] qual_cnt, qual_next;

    // Two-flop synchronizers for every asynchronous status input
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {rx_act_toggle, bb_rx_error, bb_rx_done, rx_done, tx_done, gt_powergood};
            sync2 <= sync1;
        end
    end

    assign pg_s      = sync2[0];
    assign tx_done_s = sync2[1];
    assign rx_done_s = sync2[2];
    assign bb_done_s = sync2[3];
    assign bb_err_s  = sync2[4];
    assign act_s     = sync2[5];

    assign act_edge = act_s ^ act_d;
    assign dead     = (act_cnt == ACT_SAT);
    assign healthy  = !dead && !bb_err_s && bb_done_s;
    assign all_done = tx_done_s && rx_done_s && bb_done_s;

    // Activity watchdog: free-running, independent of FSM state, saturates when RX goes quiet
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            act_d   <= 1'b0;
            act_cnt <= '0;
        end else begin
            act_d <= act_s;
            if (act_edge)
                act_cnt <= '0;
            else if (!dead)
                act_cnt <= act_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state  = state_q;
        tmr_next    = (tmr == TMR_SAT) ? tmr : tmr + 1'b1;
        qual_next   = qual_cnt;
        escal_state = (retry_cnt >= RETRY_MAX) ? FULL_RST : RX_RST;

        case (state_q)
            HOLD: begin
                if (pg_s)
                    next_state = FULL_RST;
            end
            FULL_RST: begin
                if (tmr == PULSE_LAST)
                    next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (all_done)
                    next_state = QUALIFY;
                else if (tmr == DONE_LAST)
                    next_state = escal_state;
            end
            // tmr tracks the current run of failing cycles; any healthy cycle clears it
            QUALIFY: begin
                if (healthy) begin
                    tmr_next = '0;
                    if (qual_cnt == QUAL_LAST)
                        next_state = LINK_UP;
                    else
                        qual_next = qual_cnt + 1'b1;
                end else begin
                    qual_next = '0;
                    if (tmr == DONE_LAST)
                        next_state = escal_state;
                end
            end
            LINK_UP: begin
                if (dead || bb_err_s || !rx_done_s)
                    next_state = escal_state;
            end
            RX_RST: begin
                if (tmr == PULSE_LAST)
                    next_state = WAIT_DONE;
            end
            default: next_state = HOLD;
        endcase

        // Power loss outranks a forced reset, so it is applied last
        if (force_reset)
            next_state = FULL_RST;
        if (!pg_s)
            next_state = HOLD;

        entering = (next_state != state_q) || (force_reset && pg_s);
    end

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            state_q      <= HOLD;
            tmr          <= '0;
            qual_cnt     <= '0;
            retry_cnt    <= '0;
            loss_cnt     <= '0;
            gt_reset_all <= 1'b0;
            rx_dp_reset  <= 1'b0;
            link_up      <= 1'b0;
        end else begin
            state_q  <= next_state;
            tmr      <= entering ? '0 : tmr_next;
            qual_cnt <= entering ? '0 : qual_next;

            if (entering && (next_state == FULL_RST || next_state == LINK_UP))
                retry_cnt <= '0;
            else if (entering && next_state == RX_RST && retry_cnt != 2'b11)
                retry_cnt <= retry_cnt + 1'b1;

            if (state_q == LINK_UP && next_state != LINK_UP && loss_cnt != 16'hFFFF)
                loss_cnt <= loss_cnt + 1'b1;

            // Pulses lag state entry by one cycle; gating with pg_s drops them as soon as power loss is seen
            gt_reset_all <= (state_q == FULL_RST) && pg_s;
            rx_dp_reset  <= (state_q == RX_RST) && pg_s;
            link_up      <= (next_state == LINK_UP);
        end
    end

    assign state = state_q;

endmodule
